match_sequencer: RTL and testbench

Host-facing controller that drives the MatchAccelerator note-recognition datapath over a run of bitmap regions stored in memory. For each region it:
- fetches 48 32-bit words and assembles the 1536-bit bmr vector;
- pulses start and waits for finish;
- pushes {noteReg, lengthReg} into a small result FIFO for the host.

It sits between the memory port, the host command interface and one MatchAccelerator instance.

---
 rtl/match_pkg.sv | 25 ++
 rtl/match_result_fifo.sv | 43 ++++
 rtl/match_sequencer.sv | 154 +++++++++++++++
 tb/tb_match_sequencer.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/match_pkg.sv
// Shared types and constants for the match sequencer and its result FIFO.
package match_pkg;

   localparam int unsigned WORD_W = 32;
   localparam int unsigned BMR_W  = 1536;
   localparam int unsigned WORDS  = BMR_W / WORD_W;
   localparam int unsigned WIDX_W = $clog2(WORDS);

   localparam logic [31:0] TIMEOUT_WORD = 32'hFFFF_0000;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      START,
      WAIT,
      PUSH,
      DONE
   } state_t;

   typedef struct packed {
      logic [15:0] note;
      logic [15:0] length;
   } result_t;

endpackage

// File: rtl/match_result_fifo.sv
// Small synchronous result FIFO; caller guarantees push only when space (or a same-cycle pop) exists.
module match_result_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         full_c,
   output logic         empty_c
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign empty_c = (wptr == rptr);
   assign full_c  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign dout    = mem[rptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
         mem  <= '{default: '0};
      end else begin
         if (push) begin
            mem[wptr[AW-1:0]] <= din;
            wptr              <= wptr + PW'(1);
         end
         if (pop) begin
            rptr <= rptr + PW'(1);
         end
      end
   end

endmodule

// File: rtl/match_sequencer.sv
// Walks a run of bitmap regions: fetch 48 words, kick the accelerator, queue its result for the host.
module match_sequencer
   import match_pkg::*;
#(
   parameter int unsigned STRIDE     = 192,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned TIMEOUT    = 4096
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [31:0]       cmd_base,
   input  logic [7:0]        cmd_count,
   output logic              mem_rd,
   output logic [31:0]       mem_addr,
   input  logic              mem_rvalid,
   input  logic [WORD_W-1:0] mem_rdata,
   output logic [BMR_W-1:0]  acc_bmr,
   output logic              acc_start,
   input  logic              acc_finish,
   input  logic [15:0]       acc_note,
   input  logic [15:0]       acc_length,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [31:0]       res_data,
   output logic              busy,
   output logic              done,
   output logic              err
);
   localparam int unsigned TW = $clog2(TIMEOUT);

   state_t            state;
   state_t            state_n;
   logic [31:0]       rbase;
   logic [7:0]        count_q;
   logic [7:0]        r;
   logic [WIDX_W-1:0] w;
   logic [WIDX_W-1:0] widx_c;
   logic              pending;
   logic              fin_q;
   logic [TW-1:0]     tcnt;
   result_t           cap;

   logic accept_c, word_c, last_c, issue_c, edge_c, tout_c;
   logic pop_c, push_c, full_c, empty_c;

   assign accept_c = cmd_valid && (state == IDLE);
   assign word_c   = (state == FETCH) && pending && mem_rvalid;
   assign last_c   = (w == WIDX_W'(WORDS - 1));
   // Next read goes out in the same cycle the previous data lands, keeping one read in flight.
   assign issue_c  = (state == FETCH) && (!pending || (word_c && !last_c));
   assign widx_c   = word_c ? (w + WIDX_W'(1)) : w;
   assign edge_c   = acc_finish && !fin_q;
   assign tout_c   = (state == WAIT) && !edge_c && (tcnt == TW'(TIMEOUT - 1));
   assign pop_c    = res_ready && !empty_c;
   assign push_c   = (state == PUSH) && (!full_c || pop_c);
   assign res_valid = !empty_c;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (accept_c) state_n = (cmd_count == 8'd0) ? DONE : FETCH;
         FETCH:   if (word_c && last_c) state_n = START;
         START:   state_n = WAIT;
         WAIT:    if (edge_c || tout_c) state_n = PUSH;
         PUSH:    if (push_c) state_n = (8'(r + 8'd1) == count_q) ? DONE : FETCH;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Datapath and registered status outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cmd_ready <= 1'b1;
         busy      <= 1'b0;
         acc_start <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         mem_rd    <= 1'b0;
         mem_addr  <= '0;
         acc_bmr   <= '0;
         rbase     <= '0;
         count_q   <= '0;
         r         <= '0;
         w         <= '0;
         pending   <= 1'b0;
         fin_q     <= 1'b0;
         tcnt      <= '0;
         cap       <= '0;
      end else begin
         cmd_ready <= (state_n == IDLE);
         busy      <= (state_n != IDLE);
         acc_start <= (state_n == START);
         done      <= (state == DONE);
         mem_rd    <= issue_c;
         fin_q     <= acc_finish;
         if (accept_c) begin
            rbase   <= cmd_base;
            count_q <= cmd_count;
            r       <= '0;
            w       <= '0;
            err     <= 1'b0;
         end
         if (word_c) begin
            acc_bmr[(WORDS - 1 - 32'(w)) * WORD_W +: WORD_W] <= mem_rdata;
            w       <= w + WIDX_W'(1);
            pending <= 1'b0;
         end
         if (issue_c) begin
            mem_addr <= rbase + 32'({widx_c, 2'b00});
            pending  <= 1'b1;
         end
         if (state == START) begin
            tcnt <= '0;
         end else if ((state == WAIT) && !edge_c && !tout_c) begin
            tcnt <= tcnt + TW'(1);
         end
         if ((state == WAIT) && edge_c) begin
            cap <= result_t'({acc_note, acc_length});
         end
         if (tout_c) begin
            err <= 1'b1;
            cap <= result_t'(TIMEOUT_WORD);
         end
         if (push_c) begin
            r     <= 8'(r + 8'd1);
            w     <= '0;
            rbase <= rbase + 32'(STRIDE);
         end
      end
   end

   match_result_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (32)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push_c),
      .din     (cap),
      .pop     (pop_c),
      .dout    (res_data),
      .full_c  (full_c),
      .empty_c (empty_c)
   );

endmodule

// File: tb/tb_match_sequencer.sv
// Directed bench for match_sequencer with behavioural memory and accelerator models.
module tb_match_sequencer;
   import match_pkg::*;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              cmd_valid, cmd_ready;
   logic [31:0]       cmd_base;
   logic [7:0]        cmd_count;
   logic              mem_rd, mem_rvalid;
   logic [31:0]       mem_addr, mem_rdata;
   logic [BMR_W-1:0]  acc_bmr;
   logic              acc_start, acc_finish;
   logic [15:0]       acc_note, acc_length;
   logic              res_valid, res_ready;
   logic [31:0]       res_data;
   logic              busy, done, err;

   int n_chk = 0;
   int n_bad = 0;

   // memory model state
   int          mem_lat   = 2;
   logic        mem_pend  = 1'b0;
   int          mem_cnt   = 0;
   logic [31:0] mem_paddr = '0;
   int          rd_cnt    = 0;
   int          overlap   = 0;
   logic [31:0] rd_q[$];

   // accelerator model state
   int          acc_delay  = 20;
   bit          hang_first = 1'b0;
   int          acc_k      = 0;
   int          acc_pk     = 0;
   int          acc_cnt    = -1;
   int          start_cnt  = 0;
   logic [15:0] note_base  = '0;
   logic [15:0] len_base   = '0;

   int          done_cnt = 0;
   logic [31:0] pop_q[$];

   match_sequencer dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_base   (cmd_base),
      .cmd_count  (cmd_count),
      .mem_rd     (mem_rd),
      .mem_addr   (mem_addr),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .acc_bmr    (acc_bmr),
      .acc_start  (acc_start),
      .acc_finish (acc_finish),
      .acc_note   (acc_note),
      .acc_length (acc_length),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_data   (res_data),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] bmp_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0F0F_F0F0;
   endfunction

   function automatic logic [31:0] bmr_word(input int wi);
      return acc_bmr[BMR_W - 1 - 32 * wi -: 32];
   endfunction

   function automatic logic [31:0] pop_at(input int i);
      if (i < pop_q.size()) return pop_q[i];
      return 'x;
   endfunction

   function automatic logic [31:0] rd_at(input int i);
      if (i < rd_q.size()) return rd_q[i];
      return 'x;
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Memory: one read at a time, data valid mem_lat cycles after the request.
   always @(negedge clk) begin
      if (mem_rd && mem_pend) overlap++;
      mem_rvalid = 1'b0;
      if (mem_pend) begin
         if (mem_cnt <= 1) begin
            mem_rvalid = 1'b1;
            mem_rdata  = bmp_word(mem_paddr);
            mem_pend   = 1'b0;
         end else begin
            mem_cnt--;
         end
      end
      if (mem_rd) begin
         mem_pend  = 1'b1;
         mem_cnt   = mem_lat;
         mem_paddr = mem_addr;
         rd_cnt++;
         rd_q.push_back(mem_addr);
      end
   end

   // Accelerator: finish rises acc_delay cycles after start and holds until the next start.
   always @(negedge clk) begin
      if (acc_start) begin
         start_cnt++;
         acc_finish = 1'b0;
         acc_cnt    = (hang_first && acc_k == 0) ? -1 : acc_delay;
         acc_pk     = acc_k;
         acc_k++;
      end else if (acc_cnt > 0) begin
         acc_cnt--;
         if (acc_cnt == 0) begin
            acc_finish = 1'b1;
            acc_note   = note_base + 16'(acc_pk);
            acc_length = len_base + 16'(acc_pk);
         end
      end
   end

   always @(negedge clk) begin
      if (done) done_cnt++;
      if (res_valid && res_ready) pop_q.push_back(res_data);
   end

   task automatic clr();
      rd_q.delete();
      pop_q.delete();
      rd_cnt    = 0;
      start_cnt = 0;
      acc_k     = 0;
      done_cnt  = 0;
   endtask

   task automatic send_cmd(input logic [31:0] base, input logic [7:0] cnt);
      @(posedge clk); #1;
      cmd_valid = 1'b1;
      cmd_base  = base;
      cmd_count = cnt;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int d0;
      int n;
      d0 = done_cnt;
      n  = 0;
      while (done_cnt == d0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 64'(done_cnt - d0), 64'd1);
   endtask

   task automatic wait_start(input string tag, input int budget);
      int n;
      n = 0;
      while (!acc_start && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 64'(acc_start), 64'd1);
   endtask

   initial begin
      cmd_valid  = 1'b0;
      cmd_base   = '0;
      cmd_count  = '0;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      acc_finish = 1'b0;
      acc_note   = '0;
      acc_length = '0;
      res_ready  = 1'b1;

      // reset values
      repeat (3) @(negedge clk);
      chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
      chk("rst_busy",      64'(busy),      64'd0);
      chk("rst_mem_rd",    64'(mem_rd),    64'd0);
      chk("rst_acc_start", 64'(acc_start), 64'd0);
      chk("rst_res_valid", 64'(res_valid), 64'd0);
      chk("rst_res_data",  64'(res_data),  64'd0);
      chk("rst_done",      64'(done),      64'd0);
      chk("rst_err",       64'(err),       64'd0);
      chk("rst_bmr0",      64'(bmr_word(0)), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // single region
      clr();
      note_base = 16'h0005; len_base = 16'h0004; acc_delay = 20; mem_lat = 2;
      send_cmd(32'h0000_2000, 8'd1);
      wait_done("t1_done", 2000);
      repeat (2) @(negedge clk);
      chk("t1_starts", 64'(start_cnt), 64'd1);
      chk("t1_reads",  64'(rd_cnt),    64'd48);
      for (int i = 0; i < 48; i++)
         chk($sformatf("t1_bmr%0d", i), 64'(bmr_word(i)), 64'(bmp_word(32'(32'h2000 + 4 * i))));
      chk("t1_npop",   64'(pop_q.size()), 64'd1);
      chk("t1_res",    64'(pop_at(0)), 64'h0005_0004);
      chk("t1_ndone",  64'(done_cnt),  64'd1);
      chk("t1_err",    64'(err),       64'd0);

      // three regions, address walk
      clr();
      note_base = 16'h0100; len_base = 16'h0200; acc_delay = 10;
      send_cmd(32'h0000_1000, 8'd3);
      wait_done("t2_done", 3000);
      repeat (2) @(negedge clk);
      chk("t2_reads",  64'(rd_cnt), 64'd144);
      chk("t2_a0",     64'(rd_at(0)),   64'h1000);
      chk("t2_a47",    64'(rd_at(47)),  64'h10BC);
      chk("t2_a48",    64'(rd_at(48)),  64'h10C0);
      chk("t2_a95",    64'(rd_at(95)),  64'h117C);
      chk("t2_a96",    64'(rd_at(96)),  64'h1180);
      chk("t2_a143",   64'(rd_at(143)), 64'h123C);
      chk("t2_starts", 64'(start_cnt), 64'd3);
      chk("t2_npop",   64'(pop_q.size()), 64'd3);
      chk("t2_res0",   64'(pop_at(0)), 64'h0100_0200);
      chk("t2_res1",   64'(pop_at(1)), 64'h0101_0201);
      chk("t2_res2",   64'(pop_at(2)), 64'h0102_0202);

      // backpressure: FIFO fills, sequencer stalls, then drains
      clr();
      @(posedge clk); #1;
      res_ready = 1'b0;
      note_base = 16'h0300; len_base = 16'h0400; acc_delay = 5;
      send_cmd(32'h0000_4000, 8'd6);
      repeat (1500) @(negedge clk);
      chk("t3_stall_starts", 64'(start_cnt), 64'd5);
      chk("t3_stall_busy",   64'(busy),      64'd1);
      chk("t3_stall_valid",  64'(res_valid), 64'd1);
      chk("t3_stall_ndone",  64'(done_cnt),  64'd0);
      @(posedge clk); #1;
      res_ready = 1'b1;
      wait_done("t3_done", 3000);
      repeat (2) @(negedge clk);
      chk("t3_npop", 64'(pop_q.size()), 64'd6);
      for (int k = 0; k < 6; k++)
         chk($sformatf("t3_res%0d", k), 64'(pop_at(k)),
             64'({16'(16'h0300 + k), 16'(16'h0400 + k)}));

      // timeout on first region, second region normal
      clr();
      hang_first = 1'b1;
      note_base = 16'h0500; len_base = 16'h0600; acc_delay = 8;
      send_cmd(32'h0000_5000, 8'd2);
      wait_start("t4_start", 1000);
      repeat (4096) @(negedge clk);
      chk("t4_err_pre", 64'(err), 64'd0);
      @(negedge clk);
      chk("t4_err_set", 64'(err), 64'd1);
      wait_done("t4_done", 2000);
      repeat (2) @(negedge clk);
      hang_first = 1'b0;
      chk("t4_npop",   64'(pop_q.size()), 64'd2);
      chk("t4_res0",   64'(pop_at(0)), 64'hFFFF_0000);
      chk("t4_res1",   64'(pop_at(1)), 64'h0501_0601);
      chk("t4_sticky", 64'(err), 64'd1);

      // zero-count command
      clr();
      send_cmd(32'h0000_6000, 8'd0);
      @(negedge clk);
      chk("t6_done_e1", 64'(done), 64'd0);
      chk("t6_err_clr", 64'(err),  64'd0);
      chk("t6_busy",    64'(busy), 64'd1);
      @(negedge clk);
      chk("t6_done_e2", 64'(done), 64'd1);
      @(negedge clk);
      chk("t6_done_e3", 64'(done), 64'd0);
      repeat (3) @(negedge clk);
      chk("t6_reads",  64'(rd_cnt),    64'd0);
      chk("t6_starts", 64'(start_cnt), 64'd0);
      chk("t6_ndone",  64'(done_cnt),  64'd1);

      // reset while waiting on the accelerator
      clr();
      hang_first = 1'b1;
      send_cmd(32'h0000_7000, 8'd1);
      wait_start("t5w_start", 1000);
      repeat (10) @(negedge clk);
      chk("t5w_busy_pre", 64'(busy), 64'd1);
      rst = 1'b1;
      #1;
      chk("t5w_cmd_ready", 64'(cmd_ready), 64'd1);
      chk("t5w_busy",      64'(busy),      64'd0);
      chk("t5w_acc_start", 64'(acc_start), 64'd0);
      chk("t5w_bmr0",      64'(bmr_word(0)), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      hang_first = 1'b0;

      // reset with a read outstanding; the late rvalid must be ignored
      clr();
      mem_lat = 10;
      send_cmd(32'h0000_8000, 8'd1);
      begin
         int n;
         n = 0;
         while (!mem_rd && n < 100) begin
            @(negedge clk);
            n++;
         end
      end
      chk("t5f_rd_seen", 64'(mem_rd), 64'd1);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("t5f_mem_rd",    64'(mem_rd),    64'd0);
      chk("t5f_mem_addr",  64'(mem_addr),  64'd0);
      chk("t5f_busy",      64'(busy),      64'd0);
      chk("t5f_cmd_ready", 64'(cmd_ready), 64'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (15) @(negedge clk);
      chk("t5f_late_gone", 64'(mem_pend),    64'd0);
      chk("t5f_idle",      64'(busy),        64'd0);
      chk("t5f_bmr0",      64'(bmr_word(0)), 64'd0);
      chk("t5f_reads",     64'(rd_cnt),      64'd1);

      // fresh command after resets
      clr();
      mem_lat = 2;
      note_base = 16'h0700; len_base = 16'h0800; acc_delay = 12;
      send_cmd(32'h0000_9000, 8'd1);
      wait_done("t5n_done", 2000);
      repeat (2) @(negedge clk);
      chk("t5n_reads", 64'(rd_cnt),    64'd48);
      chk("t5n_a0",    64'(rd_at(0)),  64'h9000);
      chk("t5n_bmr0",  64'(bmr_word(0)),  64'(bmp_word(32'h9000)));
      chk("t5n_bmr47", 64'(bmr_word(47)), 64'(bmp_word(32'h90BC)));
      chk("t5n_res",   64'(pop_at(0)), 64'h0700_0800);
      chk("t5n_err",   64'(err),       64'd0);

      chk("overlap", 64'(overlap), 64'd0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
